pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register with valid/ready handshake, synchronous flush and a bubble counter.
- Successor to the fixed decode/execute register. It is intended for every stage boundary: F/D, D/E, E/M and M/W.
- Payload is split into a control field (zeroed on flush and masked when invalid) and a data field (zeroed on flush only if configured).
- Sits between the hazard unit (drives sig_clr and stalls via out_ready) and adjacent stage logic.

Parameters:
- CTRL_W, 12, width of control field (reg_write, mem_to_reg, mem_write, alu_control, alu_src, reg_dst, ...).
- DATA_W, 111, width of data field (operands, register indices, immediate).
- CLR_DATA, 1, 1 = flush also zeroes stored data; 0 = flush leaves data unchanged and clears control and valid only.
- CNT_W, 16, width of bubble counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_clr  in  1  synchronous flush from hazard unit.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  stored entry valid.
- out_ready  in  1  downstream accepts (0 = stall).
- out_ctrl  out  CTRL_W  control field, forced to 0 when out_valid=0.
- out_data  out  DATA_W  data field (unmasked).
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): all storage valid bits, control, data and bubble_cnt go to 0, so out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0. in_ready=1 after reset releases.
- Transfer in: in_valid & in_ready at posedge. Transfer out: out_valid & out_ready at posedge.
- Baseline (no macro): single entry, latency 1 cycle.
  - in_ready = !out_valid | out_ready. This is a combinational path from out_ready.
  - On input transfer: the entry loads in_ctrl/in_data and out_valid becomes 1.
  - On output transfer with no input transfer: out_valid becomes 0. ctrl is cleared; data is held.
  - Stall (out_valid=1, out_ready=0): entry held bit-exact, in_ready=0.
- Flush: sig_clr=1 at posedge has priority over every transfer.
  - All entries become invalid and stored ctrl goes to 0. Data goes to 0 iff CLR_DATA=1.
  - An input presented in the same cycle is discarded, not stored.
  - in_ready is not gated by sig_clr.
  - sig_clr held for N cycles leaves out_valid=0 for those N cycles plus the cycle after.
- Masking: out_ctrl = out_valid ? stored_ctrl : 0 at all times, so a bubble can never assert reg_write or mem_write.
- bubble_cnt: increments by 1 at every posedge where out_ready=1 and out_valid=0. It saturates at all-ones with no wrap and is cleared only by reset; flush does not clear it.
- Simultaneous input and output transfer in the same cycle: the new entry replaces the old, out_valid stays 1, giving full throughput of 1 per cycle.

Optional Feature:
- Macro PIPE_STAGE_SKID_EN.
- Defined: a two-entry skid buffer (main plus skid) replaces the single entry, and in_ready comes directly from a flop (in_ready = skid empty), removing the out_ready-to-in_ready combinational path.
  - Input arriving while the main entry is stalled goes to skid.
  - When main drains, skid moves to main in the same cycle as the output transfer.
  - Order is strictly FIFO and latency is still 1 cycle when not stalled.
  - Flush invalidates both entries.
  - in_ready drops the cycle after skid fills and rises the cycle after skid empties.
- Undefined: baseline single-entry behaviour above.

Test Plan:
- Reset mid-stream: load ctrl=0xABC, data=5; assert rst_n=0 asynchronously between edges -> out_valid, out_ctrl, out_data and bubble_cnt all 0 immediately; in_ready=1 after release.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with data 1..8 -> out_data shows 1..8 on consecutive cycles starting 1 cycle after the first, with no bubbles.
- Stall: hold out_ready=0 for 3 cycles with entry data=0x22 -> out_data stays 0x22 and in_ready=0 throughout. Under PIPE_STAGE_SKID_EN, the next input 0x23 is captured once and emitted directly after 0x22.
- Flush with concurrent input: entry valid ctrl=0xFFF; sig_clr=1 while in_valid=1 with data=0x99 -> next cycle out_valid=0 and out_ctrl=0; out_data=0 when CLR_DATA=1, or the old data when CLR_DATA=0; 0x99 never appears.
- Bubble counter: out_ready=1 and in_valid=0 for 10 cycles -> bubble_cnt=10. Preload with CNT_W=4 and run 20 bubble cycles -> saturates at 15.
- Masking: valid entry with ctrl=0x3FF, then drain with no new input -> out_ctrl=0 while out_data retains the last value.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, flush and bubble counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int CTRL_W   = 12,
    parameter int DATA_W   = 111,
    parameter bit CLR_DATA = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic              valid_nxt_s;
    logic [CTRL_W-1:0] ctrl_nxt_s;
    logic [DATA_W-1:0] data_nxt_s;
    logic              in_xfer_s;

    // Control is masked so a bubble can never assert reg_write or mem_write downstream.
    assign out_valid  = valid_r;
    assign out_ctrl   = valid_r ? ctrl_r : {CTRL_W{1'b0}};
    assign out_data   = data_r;
    assign bubble_cnt = bubble_cnt_r;
    assign in_xfer_s  = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic              skid_valid_nxt_s;
    logic [CTRL_W-1:0] skid_ctrl_nxt_s;
    logic [DATA_W-1:0] skid_data_nxt_s;
    logic              main_free_s;

    assign in_ready    = ~skid_valid_r;
    assign main_free_s = ~valid_r | out_ready;

    // Next-state for main and skid entries; skid refills main in the drain cycle to keep FIFO order.
    always_comb begin
        valid_nxt_s      = valid_r;
        ctrl_nxt_s       = ctrl_r;
        data_nxt_s       = data_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_ctrl_nxt_s  = skid_ctrl_r;
        skid_data_nxt_s  = skid_data_r;
        if (sig_clr) begin
            valid_nxt_s      = 1'b0;
            ctrl_nxt_s       = {CTRL_W{1'b0}};
            skid_valid_nxt_s = 1'b0;
            skid_ctrl_nxt_s  = {CTRL_W{1'b0}};
            if (CLR_DATA) begin
                data_nxt_s      = {DATA_W{1'b0}};
                skid_data_nxt_s = {DATA_W{1'b0}};
            end else begin
                data_nxt_s      = data_r;
                skid_data_nxt_s = skid_data_r;
            end
        end else if (main_free_s) begin
            if (skid_valid_r) begin
                valid_nxt_s      = 1'b1;
                ctrl_nxt_s       = skid_ctrl_r;
                data_nxt_s       = skid_data_r;
                skid_valid_nxt_s = 1'b0;
                skid_ctrl_nxt_s  = {CTRL_W{1'b0}};
            end else if (in_xfer_s) begin
                valid_nxt_s = 1'b1;
                ctrl_nxt_s  = in_ctrl;
                data_nxt_s  = in_data;
            end else begin
                valid_nxt_s = 1'b0;
                ctrl_nxt_s  = {CTRL_W{1'b0}};
            end
        end else if (in_xfer_s) begin
            skid_valid_nxt_s = 1'b1;
            skid_ctrl_nxt_s  = in_ctrl;
            skid_data_nxt_s  = in_data;
        end else begin
            skid_valid_nxt_s = skid_valid_r;
        end
    end

    // Skid entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_r <= 1'b0;
            skid_ctrl_r  <= {CTRL_W{1'b0}};
            skid_data_r  <= {DATA_W{1'b0}};
        end else begin
            skid_valid_r <= skid_valid_nxt_s;
            skid_ctrl_r  <= skid_ctrl_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
        end
    end
`else
    logic out_xfer_s;

    assign in_ready   = ~valid_r | out_ready;
    assign out_xfer_s = valid_r & out_ready;

    // Next-state for the single entry; flush wins over load and drain.
    always_comb begin
        valid_nxt_s = valid_r;
        ctrl_nxt_s  = ctrl_r;
        data_nxt_s  = data_r;
        if (sig_clr) begin
            valid_nxt_s = 1'b0;
            ctrl_nxt_s  = {CTRL_W{1'b0}};
            if (CLR_DATA) begin
                data_nxt_s = {DATA_W{1'b0}};
            end else begin
                data_nxt_s = data_r;
            end
        end else if (in_xfer_s) begin
            valid_nxt_s = 1'b1;
            ctrl_nxt_s  = in_ctrl;
            data_nxt_s  = in_data;
        end else if (out_xfer_s) begin
            valid_nxt_s = 1'b0;
            ctrl_nxt_s  = {CTRL_W{1'b0}};
        end else begin
            valid_nxt_s = valid_r;
        end
    end
`endif

    // Main entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            ctrl_r  <= {CTRL_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    // Saturating bubble counter; deliberately untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (out_ready && !valid_r && (bubble_cnt_r != {CNT_W{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; a second instance (CLR_DATA=0, CNT_W=4) shares all inputs.
module tb_pipe_stage_reg;
    localparam int CW = 12;
    localparam int DW = 111;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig_clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, in_ready_b, out_valid_b;
    logic [CW-1:0] out_ctrl, out_ctrl_b;
    logic [DW-1:0] out_data, out_data_b;
    logic [15:0]   bubble_cnt;
    logic [3:0]    bubble_cnt_b;

    int tests = 0;
    int fails = 0;
    ent_t exp_q[$];

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .sig_clr(sig_clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .bubble_cnt(bubble_cnt));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_clr(sig_clr), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_ctrl(out_ctrl_b), .out_data(out_data_b), .bubble_cnt(bubble_cnt_b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: accepted inputs in order; flush or reset empties the model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q.delete();
        else if (sig_clr) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back('{c: in_ctrl, d: in_data});
    end

    // Monitor: every presented entry must match the queue head; popped on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {out_ctrl, out_data}, 128'd0);
                end else begin
                    chk("mon_data", out_data, exp_q[0].d);
                    chk("mon_ctrl", out_ctrl, exp_q[0].c);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("mon_mask", out_ctrl, 128'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst_valid", out_valid, 128'd0);
        chk("rst_ctrl", out_ctrl, 128'd0);
        chk("rst_data", out_data, 128'd0);
        chk("rst_bubble", bubble_cnt, 128'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 128'd1);
        chk("rst_in_ready_b", in_ready_b, 128'd1);

        // Reset mid-stream, asserted between edges
        in_valid = 1'b1; in_ctrl = 12'hABC; in_data = 111'd5;
        tick();
        in_valid = 1'b0;
        chk("load_ctrl", out_ctrl, 128'hABC);
        chk("load_data", out_data, 128'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_valid", out_valid, 128'd0);
        chk("amid_ctrl", out_ctrl, 128'd0);
        chk("amid_data", out_data, 128'd0);
        chk("amid_bubble", bubble_cnt, 128'd0);
        #3 rst_n = 1'b1;
        #1;
        chk("amid_in_ready", in_ready, 128'd1);
        tick();

        // Bubble counter and saturation on the CNT_W=4 instance
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        out_ready = 1'b0;
        chk("bubble_10", bubble_cnt, 128'd10);
        chk("bubble_10_b", bubble_cnt_b, 128'd10);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        out_ready = 1'b0;
        chk("bubble_20", bubble_cnt, 128'd20);
        chk("bubble_sat_b", bubble_cnt_b, 128'd15);

        // Streaming 1..8 with no bubbles
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_ctrl = 12'(i); in_data = 111'(i);
            tick();
            chk("stream_valid", out_valid, 128'd1);
            chk("stream_data", out_data, 128'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", out_valid, 128'd0);

        // Stall with entry 0x22, next input 0x23 waiting
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'h022; in_data = 111'h22;
        tick();
        in_ctrl = 12'h023; in_data = 111'h23;
        for (int i = 0; i < 3; i++) begin
            tick();
`ifdef PIPE_STAGE_SKID_EN
            in_valid = 1'b0;
`endif
            chk("stall_data", out_data, 128'h22);
            chk("stall_valid", out_valid, 128'd1);
            chk("stall_in_ready", in_ready, 128'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("after_stall_data", out_data, 128'h23);
        tick();
        chk("after_stall_empty", out_valid, 128'd0);
        chk("after_stall_in_ready", in_ready, 128'd1);

        // Flush with a concurrent input
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'hFFF; in_data = 111'h55;
        tick();
        chk("pre_flush_ctrl", out_ctrl, 128'hFFF);
        sig_clr = 1'b1; in_ctrl = 12'h099; in_data = 111'h99;
        tick();
        chk("flush_valid", out_valid, 128'd0);
        chk("flush_ctrl", out_ctrl, 128'd0);
        chk("flush_data_clr", out_data, 128'd0);
        chk("flush_valid_b", out_valid_b, 128'd0);
        chk("flush_ctrl_b", out_ctrl_b, 128'd0);
        chk("flush_data_keep_b", out_data_b, 128'h55);
        chk("flush_in_ready", in_ready, 128'd1);
        tick();
        sig_clr = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", out_valid, 128'd0);
        chk("flush2_data_b", out_data_b, 128'h55);
        tick();
        chk("flush_after_valid", out_valid, 128'd0);

        // Masking after drain
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 12'h3FF; in_data = 111'h77;
        tick();
        in_valid = 1'b0;
        chk("mask_loaded_ctrl", out_ctrl, 128'h3FF);
        tick();
        chk("mask_valid", out_valid, 128'd0);
        chk("mask_ctrl", out_ctrl, 128'd0);
        chk("mask_data_held", out_data, 128'h77);
        chk("mask_data_held_b", out_data_b, 128'h77);
        tick();
        chk("queue_empty", exp_q.size(), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
